// File: rtl/matrix_3x3_gen_8bit_if.sv
// Pixel-stream bundle between the Sobel line-buffer stage and the 3x3 window generator.
interface matrix_3x3_gen_8bit_if;
    logic       pre_frame_vsync;
    logic       pre_frame_href;
    logic       pre_frame_clken;
    logic [7:0] pre_img_y;
    logic [7:0] taps0x;
    logic [7:0] taps1x;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;

    // Upstream side: drives the live stream and line-buffer taps, receives the window.
    modport master (
        output pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_y, taps0x, taps1x,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33
    );

    // Window generator side.
    modport slave (
        input  pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_y, taps0x, taps1x,
        output post_frame_vsync, post_frame_href, post_frame_clken,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33
    );
endinterface

// File: rtl/matrix_3x3_gen_8bit.sv
// 3x3 neighbourhood window generator for the Sobel path.
// Stage 1 registers the live pixel and frame controls so they line up with the
// line-buffer taps (one read-latency later); stage 2 shifts the window and
// replicates the top two rows and the left column at frame/line starts.
module matrix_3x3_gen_8bit #(
    parameter int unsigned COL_W = 10
) (
    input logic                   clock,
    input logic                   reset,
    matrix_3x3_gen_8bit_if.slave  bus
);

    localparam logic [COL_W-1:0] COL_ONE = {{(COL_W-1){1'b0}}, 1'b1};

    // Stage 1
    logic [7:0]       img_y_q, img_y_d;
    logic             clken_q, clken_d;
    logic             href_q, href_d;
    logic             vsync_q, vsync_d;
    logic             first_col_q, first_col_d;
    logic [1:0]       row_sel_q, row_sel_d;

    // Position counters
    logic [COL_W-1:0] col_cnt_q, col_cnt_d;
    logic [1:0]       row_cnt_q, row_cnt_d;

    // Stage 2
    logic             post_clken_q, post_clken_d;
    logic             post_href_q, post_href_d;
    logic             post_vsync_q, post_vsync_d;
    logic [2:0][2:0][7:0] win_q, win_d;   // [row: 0=top][col: 0=oldest]

    logic [2:0][7:0]  src;                // new column per row: 0=top, 2=bottom

    // Next-state logic for counters, stage-1 alignment and the window shift.
    always_comb begin
        img_y_d      = bus.pre_img_y;
        clken_d      = bus.pre_frame_clken;
        href_d       = bus.pre_frame_href;
        vsync_d      = bus.pre_frame_vsync;
        first_col_d  = (col_cnt_q == '0);
        row_sel_d    = (row_cnt_q >= 2'd2) ? 2'd2 : row_cnt_q;

        col_cnt_d = col_cnt_q;
        if (!bus.pre_frame_href) begin
            col_cnt_d = '0;
        end else if (bus.pre_frame_clken && (col_cnt_q != '1)) begin
            col_cnt_d = col_cnt_q + COL_ONE;
        end

        // Frame-start clear takes priority over a coincident end-of-line increment.
        row_cnt_d = row_cnt_q;
        if (bus.pre_frame_vsync && !vsync_q) begin
            row_cnt_d = 2'd0;
        end else if (href_q && !bus.pre_frame_href && (row_cnt_q != 2'd2)) begin
            row_cnt_d = row_cnt_q + 2'd1;
        end

        // Rows not yet available in the line buffer copy the row below them.
        src[2] = img_y_q;
        src[1] = (row_sel_q >= 2'd1) ? bus.taps0x : src[2];
        src[0] = (row_sel_q == 2'd2) ? bus.taps1x : src[1];

        win_d = win_q;
        if (clken_q) begin
            for (int unsigned r = 0; r < 3; r++) begin
                if (first_col_q) begin
                    win_d[r][0] = src[r];
                    win_d[r][1] = src[r];
                    win_d[r][2] = src[r];
                end else begin
                    win_d[r][0] = win_q[r][1];
                    win_d[r][1] = win_q[r][2];
                    win_d[r][2] = src[r];
                end
            end
        end

        post_clken_d = clken_q;
        post_href_d  = href_q;
        post_vsync_d = vsync_q;
    end

    // All pipeline state; reset empties the pipeline immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            img_y_q      <= '0;
            clken_q      <= 1'b0;
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            first_col_q  <= 1'b0;
            row_sel_q    <= '0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            post_clken_q <= 1'b0;
            post_href_q  <= 1'b0;
            post_vsync_q <= 1'b0;
            win_q        <= '0;
        end else begin
            img_y_q      <= img_y_d;
            clken_q      <= clken_d;
            href_q       <= href_d;
            vsync_q      <= vsync_d;
            first_col_q  <= first_col_d;
            row_sel_q    <= row_sel_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            post_clken_q <= post_clken_d;
            post_href_q  <= post_href_d;
            post_vsync_q <= post_vsync_d;
            win_q        <= win_d;
        end
    end

    assign bus.post_frame_vsync = post_vsync_q;
    assign bus.post_frame_href  = post_href_q;
    assign bus.post_frame_clken = post_clken_q;
    assign bus.matrix_p11 = win_q[0][0];
    assign bus.matrix_p12 = win_q[0][1];
    assign bus.matrix_p13 = win_q[0][2];
    assign bus.matrix_p21 = win_q[1][0];
    assign bus.matrix_p22 = win_q[1][1];
    assign bus.matrix_p23 = win_q[1][2];
    assign bus.matrix_p31 = win_q[2][0];
    assign bus.matrix_p32 = win_q[2][1];
    assign bus.matrix_p33 = win_q[2][2];

endmodule
